// File: rtl/axi_link_status_pkg.sv
// Shared definitions for the N-channel link status block: register map,
// STICKY/IRQ_EN field offsets, AXI response codes and the index decoder.
package axi_link_status_pkg;

    localparam logic [4:0] REG_STATUS    = 5'd0;
    localparam logic [4:0] REG_STICKY    = 5'd1;
    localparam logic [4:0] REG_IRQ_EN    = 5'd2;
    localparam logic [4:0] REG_INFO      = 5'd3;
    localparam logic [4:0] REG_OVR_BASE  = 5'd8;
    localparam logic [4:0] REG_DOWN_BASE = 5'd16;

    localparam int OVR_LSB  = 0;
    localparam int DOWN_LSB = 8;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [6:0] ADDR_MASK = 7'h7F;

    typedef enum logic [2:0] {
        K_NONE,
        K_STATUS,
        K_STICKY,
        K_IRQ_EN,
        K_INFO,
        K_OVR_CNT,
        K_DOWN_CNT
    } reg_kind_e;

    // Counter slots beyond the configured channel count decode as K_NONE.
    function automatic reg_kind_e decode_idx(input logic [4:0] idx, input int num_ch);
        int        i;
        reg_kind_e kind;
        i    = int'(idx);
        kind = K_NONE;
        if (i == int'(REG_STATUS))
            kind = K_STATUS;
        else if (i == int'(REG_STICKY))
            kind = K_STICKY;
        else if (i == int'(REG_IRQ_EN))
            kind = K_IRQ_EN;
        else if (i == int'(REG_INFO))
            kind = K_INFO;
        else if (i >= int'(REG_OVR_BASE) && i < int'(REG_OVR_BASE) + num_ch)
            kind = K_OVR_CNT;
        else if (i >= int'(REG_DOWN_BASE) && i < int'(REG_DOWN_BASE) + num_ch)
            kind = K_DOWN_CNT;
        return kind;
    endfunction

endpackage

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave front end presenting single-cycle ASHI read/write strobes
// to a register file; the register file answers writes combinationally.
module axi4_lite_slave (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output logic [31:0] ashi_waddr,
    output logic [31:0] ashi_wdata,
    output logic        ashi_write,
    input  logic [1:0]  ashi_wresp,
    output logic [31:0] ashi_raddr,
    output logic        ashi_read,
    input  logic [31:0] ashi_rdata,
    input  logic [1:0]  ashi_rresp,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a beat transfers on a rising edge where VALID and READY are
    // both high; VALID never waits on READY, and BVALID/RVALID hold until taken.
    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_RESP} rstate_e;

    wstate_e     w_state_q, w_state_d;
    rstate_e     r_state_q, r_state_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB};

    // AW and W may arrive in either order; the write fires once both are held.
    assign ashi_waddr = aw_got_q ? waddr_q : S_AXI_AWADDR;
    assign ashi_wdata = w_got_q ? wdata_q : S_AXI_WDATA;
    assign ashi_write = (w_state_q == W_IDLE) && (aw_got_q || S_AXI_AWVALID)
                        && (w_got_q || S_AXI_WVALID);

    assign S_AXI_AWREADY = (w_state_q == W_IDLE) && !aw_got_q;
    assign S_AXI_WREADY  = (w_state_q == W_IDLE) && !w_got_q;
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;

    assign ashi_raddr    = S_AXI_ARADDR;
    assign ashi_read     = (r_state_q == R_IDLE) && S_AXI_ARVALID;
    assign S_AXI_ARREADY = (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = (r_state_q == R_RESP);
    assign S_AXI_RDATA   = ashi_rdata;
    assign S_AXI_RRESP   = ashi_rresp;

    assign dbg_state_o = {w_state_q, r_state_q};

    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (ashi_write) begin
                    bresp_d   = ashi_wresp;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    if (S_AXI_AWVALID && !aw_got_q) begin
                        aw_got_d = 1'b1;
                        waddr_d  = S_AXI_AWADDR;
                    end
                    if (S_AXI_WVALID && !w_got_q) begin
                        w_got_d = 1'b1;
                        wdata_d = S_AXI_WDATA;
                    end
                end
            end
            W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (S_AXI_ARVALID) r_state_d = R_RESP;
            R_RESP:  if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            bresp_q   <= bresp_d;
        end
    end

endmodule

// File: rtl/axi_link_status_tracker.sv
// Per-channel event tracker: link-down edge detect, sticky overrun/link-down
// latches with W1C, and saturating event counters with clear.
module link_event_tracker #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 channel_up_i,
    input  logic                 overrun_i,
    input  logic                 ovr_clr_i,
    input  logic                 down_clr_i,
    input  logic                 ovr_cnt_clr_i,
    input  logic                 down_cnt_clr_i,
    output logic                 ovr_sticky_o,
    output logic                 down_sticky_o,
    output logic [CNT_WIDTH-1:0] ovr_cnt_o,
    output logic [CNT_WIDTH-1:0] down_cnt_o
);

    logic                 up_q;
    logic                 down_evt;
    logic                 ovr_sticky_q, ovr_sticky_d;
    logic                 down_sticky_q, down_sticky_d;
    logic [CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;
    logic [CNT_WIDTH-1:0] down_cnt_q, down_cnt_d;

    // A clear and an event in the same cycle leave the count at one.
    function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic evt, input logic clr);
        logic [CNT_WIDTH-1:0] base;
        base = clr ? '0 : cnt;
        if (evt && (base != '1))
            base = base + CNT_WIDTH'(1);
        return base;
    endfunction

    assign down_evt = up_q && !channel_up_i;

    always_comb begin
        ovr_sticky_d  = overrun_i || (ovr_sticky_q && !ovr_clr_i);
        down_sticky_d = down_evt || (down_sticky_q && !down_clr_i);
        ovr_cnt_d     = cnt_next(ovr_cnt_q, overrun_i, ovr_cnt_clr_i);
        down_cnt_d    = cnt_next(down_cnt_q, down_evt, down_cnt_clr_i);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            up_q          <= 1'b0;
            ovr_sticky_q  <= 1'b0;
            down_sticky_q <= 1'b0;
            ovr_cnt_q     <= '0;
            down_cnt_q    <= '0;
        end else begin
            up_q          <= channel_up_i;
            ovr_sticky_q  <= ovr_sticky_d;
            down_sticky_q <= down_sticky_d;
            ovr_cnt_q     <= ovr_cnt_d;
            down_cnt_q    <= down_cnt_d;
        end
    end

    assign ovr_sticky_o  = ovr_sticky_q;
    assign down_sticky_o = down_sticky_q;
    assign ovr_cnt_o     = ovr_cnt_q;
    assign down_cnt_o    = down_cnt_q;

endmodule

// File: rtl/axi_link_status.sv
// N-channel link status register block: live channel-up, sticky events,
// saturating counters and a maskable level interrupt over AXI4-Lite.
module axi_link_status
    import axi_link_status_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] channel_up_i,
    input  logic [NUM_CH-1:0] overrun_i,
    output logic              irq_o,
    output logic [1:0]        dbg_axi_state_o,
    input  logic [31:0]       S_AXI_AWADDR,
    input  logic [2:0]        S_AXI_AWPROT,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [31:0]       S_AXI_ARADDR,
    input  logic [2:0]        S_AXI_ARPROT,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY
);

    logic [31:0]          ashi_waddr, ashi_wdata, ashi_raddr;
    logic                 ashi_write, ashi_read;
    logic [1:0]           ashi_wresp;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [6:0]           waddr_m, raddr_m;
    logic [4:0]           widx, ridx;
    reg_kind_e            wkind, rkind;
    logic [NUM_CH-1:0]    irq_en_ovr_q, irq_en_ovr_d;
    logic [NUM_CH-1:0]    irq_en_down_q, irq_en_down_d;
    logic [NUM_CH-1:0]    ovr_clr, down_clr, ovr_cnt_clr, down_cnt_clr;
    logic [NUM_CH-1:0]    sticky_ovr, sticky_down;
    logic [CNT_WIDTH-1:0] ovr_cnt [NUM_CH];
    logic [CNT_WIDTH-1:0] down_cnt [NUM_CH];
    logic [31:0]          sticky_word, irq_en_word;
    logic                 irq_q, irq_d;
    logic                 unused_bits;

    axi4_lite_slave u_axi (
        .clk           (clk),
        .resetn        (resetn),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ashi_waddr    (ashi_waddr),
        .ashi_wdata    (ashi_wdata),
        .ashi_write    (ashi_write),
        .ashi_wresp    (ashi_wresp),
        .ashi_raddr    (ashi_raddr),
        .ashi_read     (ashi_read),
        .ashi_rdata    (rdata_q),
        .ashi_rresp    (rresp_q),
        .dbg_state_o   (dbg_axi_state_o)
    );

    assign waddr_m = ashi_waddr[6:0] & ADDR_MASK;
    assign raddr_m = ashi_raddr[6:0] & ADDR_MASK;
    assign widx    = waddr_m[6:2];
    assign ridx    = raddr_m[6:2];
    assign wkind   = decode_idx(widx, NUM_CH);
    assign rkind   = decode_idx(ridx, NUM_CH);

    assign unused_bits = ^{ashi_waddr[31:7], ashi_raddr[31:7], waddr_m[1:0],
                           raddr_m[1:0], ashi_wdata};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        link_event_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_trk (
            .clk            (clk),
            .resetn         (resetn),
            .channel_up_i   (channel_up_i[g]),
            .overrun_i      (overrun_i[g]),
            .ovr_clr_i      (ovr_clr[g]),
            .down_clr_i     (down_clr[g]),
            .ovr_cnt_clr_i  (ovr_cnt_clr[g]),
            .down_cnt_clr_i (down_cnt_clr[g]),
            .ovr_sticky_o   (sticky_ovr[g]),
            .down_sticky_o  (sticky_down[g]),
            .ovr_cnt_o      (ovr_cnt[g]),
            .down_cnt_o     (down_cnt[g])
        );
    end

    always_comb begin
        sticky_word = '0;
        sticky_word[OVR_LSB +: NUM_CH]  = sticky_ovr;
        sticky_word[DOWN_LSB +: NUM_CH] = sticky_down;
        irq_en_word = '0;
        irq_en_word[OVR_LSB +: NUM_CH]  = irq_en_ovr_q;
        irq_en_word[DOWN_LSB +: NUM_CH] = irq_en_down_q;
    end

    // Write effects land in the same cycle as the strobe; the response is
    // returned combinationally so the AXI core never has to wait.
    always_comb begin
        ashi_wresp    = OKAY;
        irq_en_ovr_d  = irq_en_ovr_q;
        irq_en_down_d = irq_en_down_q;
        ovr_clr       = '0;
        down_clr      = '0;
        ovr_cnt_clr   = '0;
        down_cnt_clr  = '0;
        if (ashi_write) begin
            case (wkind)
                K_NONE:   ashi_wresp = DECERR;
                K_STICKY: begin
                    ovr_clr  = ashi_wdata[OVR_LSB +: NUM_CH];
                    down_clr = ashi_wdata[DOWN_LSB +: NUM_CH];
                end
                K_IRQ_EN: begin
                    irq_en_ovr_d  = ashi_wdata[OVR_LSB +: NUM_CH];
                    irq_en_down_d = ashi_wdata[DOWN_LSB +: NUM_CH];
                end
                K_OVR_CNT: begin
                    for (int ch = 0; ch < NUM_CH; ch++)
                        if (widx == 5'(int'(REG_OVR_BASE) + ch)) ovr_cnt_clr[ch] = 1'b1;
                end
                K_DOWN_CNT: begin
                    for (int ch = 0; ch < NUM_CH; ch++)
                        if (widx == 5'(int'(REG_DOWN_BASE) + ch)) down_cnt_clr[ch] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ashi_read) begin
            rdata_d = '0;
            rresp_d = OKAY;
            case (rkind)
                K_NONE:   rresp_d = DECERR;
                K_STATUS: rdata_d[NUM_CH-1:0] = channel_up_i;
                K_STICKY: rdata_d = sticky_word;
                K_IRQ_EN: rdata_d = irq_en_word;
                K_INFO:   rdata_d = {16'd0, 8'(CNT_WIDTH), 8'(NUM_CH)};
                K_OVR_CNT: begin
                    for (int ch = 0; ch < NUM_CH; ch++)
                        if (ridx == 5'(int'(REG_OVR_BASE) + ch)) rdata_d = 32'(ovr_cnt[ch]);
                end
                K_DOWN_CNT: begin
                    for (int ch = 0; ch < NUM_CH; ch++)
                        if (ridx == 5'(int'(REG_DOWN_BASE) + ch)) rdata_d = 32'(down_cnt[ch]);
                end
                default: ;
            endcase
        end
    end

    assign irq_d = |(sticky_ovr & irq_en_ovr_q) | |(sticky_down & irq_en_down_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq_en_ovr_q  <= '0;
            irq_en_down_q <= '0;
            irq_q         <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= OKAY;
        end else begin
            irq_en_ovr_q  <= irq_en_ovr_d;
            irq_en_down_q <= irq_en_down_d;
            irq_q         <= irq_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: tb/tb_axi_link_status.sv
// Directed bench for axi_link_status: instance A uses 16-bit counters,
// instance B shares every input but uses 4-bit counters to show saturation.
module tb_axi_link_status;

    logic        clk;
    logic        resetn;
    logic [1:0]  channel_up;
    logic [1:0]  overrun;
    logic [31:0] awaddr, wdata, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;

    logic        irq_a, irq_b;
    logic [1:0]  dbg_a, dbg_b;
    logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a;
    logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b;
    logic [1:0]  bresp_a, rresp_a, bresp_b, rresp_b;
    logic [31:0] rdata_a, rdata_b;

    int n_vec = 0;
    int n_err = 0;

    axi_link_status #(.NUM_CH(2), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .resetn(resetn), .channel_up_i(channel_up), .overrun_i(overrun),
        .irq_o(irq_a), .dbg_axi_state_o(dbg_a),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready_a), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_a), .S_AXI_BRESP(bresp_a),
        .S_AXI_BVALID(bvalid_a), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_a),
        .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a), .S_AXI_RVALID(rvalid_a),
        .S_AXI_RREADY(rready)
    );

    axi_link_status #(.NUM_CH(2), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .resetn(resetn), .channel_up_i(channel_up), .overrun_i(overrun),
        .irq_o(irq_b), .dbg_axi_state_o(dbg_b),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready_b), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_b), .S_AXI_BRESP(bresp_b),
        .S_AXI_BVALID(bvalid_b), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_b),
        .S_AXI_RDATA(rdata_b), .S_AXI_RRESP(rresp_b), .S_AXI_RVALID(rvalid_b),
        .S_AXI_RREADY(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // pulse drives overrun only during the cycle the write is accepted.
    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] pulse, input logic [1:0] exp_resp);
        int n;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; overrun = pulse;
        n = 0;
        @(negedge clk);
        while (!(awready_a && wready_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(awready_a & wready_a), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; overrun = 2'b00; bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bvalid"}, 32'(bvalid_a), 32'd1);
        chk({tag, "_bresp"}, 32'(bresp_a), 32'(exp_resp));
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_a,
                            input logic [31:0] exp_b, input logic [1:0] exp_resp);
        int n;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rvalid_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rvalid"}, 32'(rvalid_a), 32'd1);
        chk({tag, "_data_a"}, rdata_a, exp_a);
        chk({tag, "_data_b"}, rdata_b, exp_b);
        chk({tag, "_rresp"}, 32'(rresp_a), 32'(exp_resp));
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; channel_up = 2'b01; overrun = 2'b00;
        awaddr = '0; wdata = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (4) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_irq_a", 32'(irq_a), 32'd0);
        chk("rst_irq_b", 32'(irq_b), 32'd0);
        chk("rst_dbg", 32'(dbg_a), 32'd0);
        axi_read("rst_status", 32'h00, 32'h1, 32'h1, 2'b00);
        axi_read("rst_sticky", 32'h04, 32'h0, 32'h0, 2'b00);
        axi_read("rst_irq_en", 32'h08, 32'h0, 32'h0, 2'b00);
        axi_read("rst_info", 32'h0C, 32'h0000_1002, 32'h0000_0402, 2'b00);
        axi_read("rst_ovr0", 32'h20, 32'h0, 32'h0, 2'b00);

        // Overrun burst on channel 1 with its interrupt enabled
        axi_write("en_ovr1", 32'h08, 32'h2, 2'b00, 2'b00);
        axi_read("en_ovr1_rb", 32'h08, 32'h2, 32'h2, 2'b00);
        @(posedge clk); #1 overrun = 2'b10;
        @(posedge clk);
        @(negedge clk) chk("irq_lag", 32'(irq_a), 32'd0);
        @(posedge clk);
        @(negedge clk) chk("irq_rise", 32'(irq_a), 32'd1);
        @(posedge clk); #1 overrun = 2'b00;
        axi_read("ovr1_sticky", 32'h04, 32'h2, 32'h2, 2'b00);
        axi_read("ovr1_cnt", 32'h24, 32'h3, 32'h3, 2'b00);
        axi_write("w1c_ovr1", 32'h04, 32'h2, 2'b00, 2'b00);
        chk("irq_fall", 32'(irq_a), 32'd0);
        axi_read("w1c_sticky", 32'h04, 32'h0, 32'h0, 2'b00);
        axi_read("w1c_keeps_cnt", 32'h24, 32'h3, 32'h3, 2'b00);

        // Channel 0 link: 1 -> 0 -> 1 -> 0 gives two falling-edge events
        @(posedge clk); #1 channel_up = 2'b00;
        repeat (2) @(posedge clk);
        #1 channel_up = 2'b01;
        repeat (2) @(posedge clk);
        #1 channel_up = 2'b00;
        repeat (2) @(posedge clk);
        axi_read("down0_cnt", 32'h40, 32'h2, 32'h2, 2'b00);
        axi_read("down1_cnt", 32'h44, 32'h0, 32'h0, 2'b00);
        axi_read("down_sticky", 32'h04, 32'h100, 32'h100, 2'b00);
        axi_read("status_down", 32'h00, 32'h0, 32'h0, 2'b00);
        chk("irq_masked", 32'(irq_a), 32'd0);
        axi_write("en_all", 32'h08, 32'hFFFF_FFFF, 2'b00, 2'b00);
        axi_read("en_all_rb", 32'h08, 32'h0303, 32'h0303, 2'b00);
        chk("irq_down", 32'(irq_a), 32'd1);
        axi_write("w1c_all", 32'h04, 32'hFFFF_FFFF, 2'b00, 2'b00);
        chk("irq_cleared", 32'(irq_a), 32'd0);
        axi_read("w1c_all_rb", 32'h04, 32'h0, 32'h0, 2'b00);

        // Set wins over clear, on both the latch and the counter
        @(posedge clk); #1 overrun = 2'b01;
        repeat (2) @(posedge clk);
        #1 overrun = 2'b00;
        axi_write("w1c_vs_set", 32'h04, 32'h1, 2'b01, 2'b00);
        axi_read("w1c_vs_set_rb", 32'h04, 32'h1, 32'h1, 2'b00);
        axi_read("ovr0_cnt3", 32'h20, 32'h3, 32'h3, 2'b00);
        axi_write("clr_vs_evt", 32'h20, 32'h0, 2'b01, 2'b00);
        axi_read("clr_vs_evt_rb", 32'h20, 32'h1, 32'h1, 2'b00);

        // Saturation: 20 overrun cycles, 4-bit counter stops at 15
        axi_write("clr_ovr0", 32'h20, 32'h0, 2'b00, 2'b00);
        @(posedge clk); #1 overrun = 2'b01;
        repeat (20) @(posedge clk);
        #1 overrun = 2'b00;
        axi_read("sat", 32'h20, 32'd20, 32'd15, 2'b00);

        // Undefined indices and read-only registers
        axi_read("dec_5", 32'h14, 32'h0, 32'h0, 2'b11);
        axi_read("dec_10", 32'h28, 32'h0, 32'h0, 2'b11);
        axi_read("dec_31", 32'h7C, 32'h0, 32'h0, 2'b11);
        axi_write("wdec_31", 32'h7C, 32'hFFFF_FFFF, 2'b00, 2'b11);
        axi_read("wdec_sticky", 32'h04, 32'h1, 32'h1, 2'b00);
        axi_read("wdec_irq_en", 32'h08, 32'h0303, 32'h0303, 2'b00);
        axi_read("wdec_ovr0", 32'h20, 32'd20, 32'd15, 2'b00);
        axi_write("w_status", 32'h00, 32'hFFFF, 2'b00, 2'b00);
        axi_write("w_info", 32'h0C, 32'h0, 2'b00, 2'b00);
        axi_read("info_alias", 32'h8C, 32'h0000_1002, 32'h0000_0402, 2'b00);
        axi_write("clr_ovr1", 32'h24, 32'h1234, 2'b00, 2'b00);
        axi_read("clr_ovr1_rb", 32'h24, 32'h0, 32'h0, 2'b00);
        axi_write("clr_down0", 32'h40, 32'h0, 2'b00, 2'b00);
        axi_read("clr_down0_rb", 32'h40, 32'h0, 32'h0, 2'b00);

        // Reset during an overrun burst with a read response pending
        @(posedge clk); #1 overrun = 2'b11; araddr = 32'h04; arvalid = 1'b1;
        @(posedge clk); #1 arvalid = 1'b0;
        @(negedge clk) chk("pend_rvalid", 32'(rvalid_a), 32'd1);
        @(posedge clk);
        @(negedge clk) chk("pend_irq", 32'(irq_a), 32'd1);
        @(posedge clk); #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 overrun = 2'b00; resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(rvalid_a), 32'd0);
        chk("mid_rst_dbg", 32'(dbg_a), 32'd0);
        chk("mid_rst_irq", 32'(irq_a), 32'd0);
        axi_read("mid_rst_sticky", 32'h04, 32'h0, 32'h0, 2'b00);
        axi_read("mid_rst_irq_en", 32'h08, 32'h0, 32'h0, 2'b00);
        axi_read("mid_rst_ovr0", 32'h20, 32'h0, 32'h0, 2'b00);
        axi_read("mid_rst_ovr1", 32'h24, 32'h0, 32'h0, 2'b00);
        axi_read("mid_rst_down0", 32'h40, 32'h0, 32'h0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
